// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg -- shared definitions for the cp0_vec system-control coprocessor.
//
// Contents:
//   * CP0 register indices used by MFC0/MTC0.
//   * Exception codes that the coprocessor gives special treatment to.
//   * Bit positions of the Status (SR) and Cause fields.
//   * Helpers for the EPC value and for address-error detection.
// -----------------------------------------------------------------------------
package cp0_pkg;

    // Register indices
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_SR       = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    // Exception codes
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // SR / Cause bit positions. IM (SR) and IP (Cause) share the same
    // bits and grow downward from bit 15 as the line count increases.
    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int IM_HI_BIT    = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_BD_BIT = 31;

    // Return address for a trap: word-aligned PC, backed up to the branch
    // when the faulting instruction sits in a delay slot.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return {pc[31:2], 2'b00} - (bd ? 32'd4 : 32'd0);
    endfunction

    // Only address errors record the faulting address.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer -- Count/Compare cycle timer for cp0_vec.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   count_we     MTC0 to Count this cycle (load wins over increment)
//   compare_we   MTC0 to Compare this cycle (also clears timer_pend)
//   wr_data      MTC0 data
//   count        current Count value
//   compare      current Compare value
//   timer_pend   sticky timer-match flag
// -----------------------------------------------------------------------------
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pend
);

    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic        pend_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg   <= '0;
            compare_reg <= '0;
            pend_reg    <= 1'b0;
        end else begin
            // Free-running counter; natural 32-bit wrap.
            if (count_we) begin
                count_reg <= wr_data;
            end else begin
                count_reg <= count_reg + 32'd1;
            end

            if (compare_we) begin
                compare_reg <= wr_data;
            end

            // Rewriting Compare is the acknowledge, so it beats a
            // simultaneous match.
            if (compare_we) begin
                pend_reg <= 1'b0;
            end else if (count_reg == compare_reg) begin
                pend_reg <= 1'b1;
            end
        end
    end

    assign count      = count_reg;
    assign compare    = compare_reg;
    assign timer_pend = pend_reg;

endmodule

// File: rtl/cp0_vec.sv
// -----------------------------------------------------------------------------
// cp0_vec -- system-control coprocessor beside the M stage.
//
// Holds SR, Cause, EPC, PRId and BadVAddr (plus Count/Compare when the timer
// is built), arbitrates interrupts against synchronous exceptions and raises
// `take` to flush the pipe and redirect to the handler.
//
// Build option: define CP0_TIMER_EN to include the Count/Compare timer
// (cp0_timer). Without it Count/Compare read 0 and timer_irq is 0.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset
//   rd_addr    MFC0 register index;  rd_data  MFC0 data (combinational)
//   we         MTC0 enable; wr_addr index; wr_data data
//   pc_m       PC of the M-stage instruction
//   bd_m       M-stage instruction is in a delay slot
//   exc_valid  M-stage instruction raises an exception; exc_code its code
//   bad_vaddr  faulting address for AdEL/AdES
//   hwint      level-sensitive external interrupt lines
//   eret       ERET retiring in M
//   take       trap taken this cycle
//   epc_out    current EPC
//   timer_irq  timer pending
// -----------------------------------------------------------------------------
module cp0_vec
    import cp0_pkg::*;
#(
    parameter int                   NUM_HWINT = 6,   // 1..8
    parameter logic [31:0]          PRID_VAL  = 32'h12345678,
    parameter logic [NUM_HWINT-1:0] RESET_IM  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           rd_addr,
    output logic [31:0]          rd_data,
    input  logic                 we,
    input  logic [4:0]           wr_addr,
    input  logic [31:0]          wr_data,
    input  logic [31:0]          pc_m,
    input  logic                 bd_m,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          bad_vaddr,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 eret,
    output logic                 take,
    output logic [31:0]          epc_out,
    output logic                 timer_irq
);

    localparam int IM_LO = IM_HI_BIT + 1 - NUM_HWINT;

    // Architectural state
    logic [NUM_HWINT-1:0] im_reg;
    logic [NUM_HWINT-1:0] ip_reg;
    logic                 exl_reg;
    logic                 ie_reg;
    logic                 bd_reg;
    logic [4:0]           exc_code_reg;
    logic [31:0]          epc_reg;
    logic [31:0]          badvaddr_reg;

    // Timer view
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        timer_pend;

    // MTC0 decodes
    logic sr_we;
    logic epc_we;
    assign sr_we  = we && (wr_addr == CP0_SR);
    assign epc_we = we && (wr_addr == CP0_EPC);

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (we && (wr_addr == CP0_COUNT)),
        .compare_we (we && (wr_addr == CP0_COMPARE)),
        .wr_data    (wr_data),
        .count      (count_val),
        .compare    (compare_val),
        .timer_pend (timer_pend)
    );
`else
    assign count_val   = '0;
    assign compare_val = '0;
    assign timer_pend  = 1'b0;
`endif

    assign timer_irq = timer_pend;

    // Timer shares the top interrupt line with the external source.
    logic [NUM_HWINT-1:0] pend;
    always_comb begin
        pend                = hwint;
        pend[NUM_HWINT-1]   = hwint[NUM_HWINT-1] | timer_pend;
    end

    // Trap arbitration
    logic int_req;
    logic exc_req;
    logic trap_req;
    assign int_req  = (|(ip_reg & im_reg)) & ie_reg & ~exl_reg;
    assign exc_req  = exc_valid & ~exl_reg;
    assign trap_req = int_req | exc_req;
    // A raised exc_valid during reset must not leak out as a trap.
    assign take     = trap_req & reset;

    // Place IM / IP into their 32-bit register images.
    logic [31:0] im_field;
    logic [31:0] ip_field;
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_field
            if (gi >= IM_LO && gi <= IM_HI_BIT) begin : g_map
                assign im_field[gi] = im_reg[gi - IM_LO];
                assign ip_field[gi] = ip_reg[gi - IM_LO];
            end else begin : g_zero
                assign im_field[gi] = 1'b0;
                assign ip_field[gi] = 1'b0;
            end
        end
    endgenerate

    logic [31:0] sr_word;
    logic [31:0] cause_word;
    assign sr_word    = im_field | {30'b0, exl_reg, ie_reg};
    assign cause_word = {bd_reg, 31'b0} | ip_field | {25'b0, exc_code_reg, 2'b00};

    // MFC0 read mux
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CP0_SR:       rd_data = sr_word;
            CP0_CAUSE:    rd_data = cause_word;
            CP0_EPC:      rd_data = epc_reg;
            CP0_PRID:     rd_data = PRID_VAL;
            CP0_BADVADDR: rd_data = badvaddr_reg;
            CP0_COUNT:    rd_data = count_val;
            CP0_COMPARE:  rd_data = compare_val;
            default:      rd_data = '0;
        endcase
    end

    assign epc_out = epc_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_reg       <= RESET_IM;
            ip_reg       <= '0;
            exl_reg      <= 1'b0;
            ie_reg       <= 1'b0;
            bd_reg       <= 1'b0;
            exc_code_reg <= '0;
            epc_reg      <= '0;
            badvaddr_reg <= '0;
        end else begin
            ip_reg <= pend;

            // IM and IE never collide with a trap, so MTC0 always lands.
            if (sr_we) begin
                im_reg <= wr_data[IM_HI_BIT:IM_LO];
                ie_reg <= wr_data[SR_IE_BIT];
            end

            // EXL: trap entry beats MTC0, MTC0 beats ERET.
            if (trap_req) begin
                exl_reg <= 1'b1;
            end else if (sr_we) begin
                exl_reg <= wr_data[SR_EXL_BIT];
            end else if (eret) begin
                exl_reg <= 1'b0;
            end

            if (trap_req) begin
                bd_reg       <= bd_m;
                epc_reg      <= epc_of(pc_m, bd_m);
                exc_code_reg <= int_req ? EXC_INT : exc_code;
                if (!int_req && is_addr_exc(exc_code)) begin
                    badvaddr_reg <= bad_vaddr;
                end
            end else if (epc_we) begin
                epc_reg <= wr_data;
            end
        end
    end

    // Bits of the inputs that no register stores.
    logic unused_bits;
    assign unused_bits = ^{wr_data[31:16], wr_data[IM_LO-1:2], pc_m[1:0]};

endmodule
